// File: rtl/kp_pkg.sv
// kp_pkg: keypad key codes, one-hot entry FSM encoding and seven-segment lookup (active-low {dp,g,f,e,d,c,b,a})
package kp_pkg;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_BSP = 4'hF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  typedef enum logic [2:0] {S_IDLE = 3'b001, S_EDIT = 3'b010, S_COMMIT = 3'b100} kp_state_t;
  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexes up to MAX_DIGITS BCD digits (digits/len in) onto active-low seg_an/seg_out, one slot per SCAN_DIV clocks
module seg_scan_mux import kp_pkg::*; #(
  parameter int MAX_DIGITS = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [3:0]  len,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  logic [PW-1:0] pre;
  logic [2:0] idx;
  logic vis;
  logic wrap;
  assign vis = {1'b0, idx} < len;
  assign wrap = pre == PW'(SCAN_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
      seg_an <= 8'hFF;
      seg_out <= SEG_BLANK;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) idx <= (idx == 3'(MAX_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      seg_an <= vis ? ~(8'b1 << idx) : 8'hFF;
      seg_out <= vis ? seg_lut(digits[{idx, 2'b00} +: 4]) : SEG_BLANK;
    end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: BCD keypad entry (key_valid/key_code in) committing entry_value/entry_len/entry_valid, key_reject on dropped keys, drives seg_an/seg_out
module keypad_entry_ctrl import kp_pkg::*; #(
  parameter int MAX_DIGITS = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [31:0] entry_value,
  output logic [3:0]  entry_len,
  output logic        entry_valid,
  output logic        key_reject,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);
  kp_state_t state, state_n;
  logic [31:0] dig_buf, buf_n, val_n;
  logic [3:0] len, len_n, elen_n;
  logic show, show_n, valid_n, rej_n;
  always_comb begin
    state_n = state;
    buf_n = dig_buf;
    len_n = len;
    show_n = show;
    val_n = entry_value;
    elen_n = entry_len;
    valid_n = 1'b0;
    rej_n = 1'b0;
    if (state == S_COMMIT) begin
      state_n = S_IDLE;
      rej_n = key_valid;
    end else if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (len < 4'(MAX_DIGITS)) begin
          buf_n = {dig_buf[27:0], key_code};
          len_n = len + 4'd1;
          show_n = 1'b0;
          state_n = S_EDIT;
        end else rej_n = 1'b1;
      end else if (key_code == KEY_CLR) begin
        buf_n = '0;
        len_n = '0;
        show_n = 1'b0;
        state_n = S_IDLE;
      end else if (key_code == KEY_BSP && len != 4'd0) begin
        buf_n = {4'h0, dig_buf[31:4]};
        len_n = len - 4'd1;
        state_n = (len == 4'd1) ? S_IDLE : S_EDIT;
      end else if (key_code == KEY_ENT && len != 4'd0) begin
        state_n = S_COMMIT;
        val_n = dig_buf;
        elen_n = len;
        valid_n = 1'b1;
        show_n = 1'b1;
        buf_n = '0;
        len_n = '0;
      end else rej_n = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      dig_buf <= '0;
      len <= '0;
      show <= 1'b0;
      entry_value <= '0;
      entry_len <= '0;
      entry_valid <= 1'b0;
      key_reject <= 1'b0;
    end else begin
      state <= state_n;
      dig_buf <= buf_n;
      len <= len_n;
      show <= show_n;
      entry_value <= val_n;
      entry_len <= elen_n;
      entry_valid <= valid_n;
      key_reject <= rej_n;
    end
  seg_scan_mux #(.MAX_DIGITS(MAX_DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .digits(show ? entry_value : dig_buf),
    .len(show ? entry_len : len),
    .seg_an(seg_an),
    .seg_out(seg_out)
  );
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed keypad sequences checked every cycle against a digit-queue model plus literal expectations
module tb_keypad_entry_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [31:0] entry_value;
  logic [3:0] entry_len;
  logic entry_valid, key_reject;
  logic [7:0] seg_an, seg_out;
  int total = 0, bad = 0, ev_cnt = 0;
  bit chk_en = 1'b0;
  int q[$], cq[$];
  logic [31:0] m_val;
  int m_len, t;
  bit m_valid, m_rej, m_show, m_commit;
  logic [7:0] m_an, m_seg;
  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  keypad_entry_ctrl #(.MAX_DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .entry_value(entry_value), .entry_len(entry_len), .entry_valid(entry_valid),
    .key_reject(key_reject), .seg_an(seg_an), .seg_out(seg_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack(input int d[$]);
    logic [31:0] v = 0;
    foreach (d[i]) v = v * 16 + 32'(d[i]);
    return v;
  endfunction
  task automatic model_edge();
    int idx, slen, d;
    if (!rst_n) begin
      q.delete(); cq.delete();
      m_val = 0; m_len = 0; m_valid = 0; m_rej = 0; m_show = 0; m_commit = 0; t = 0;
      m_an = 8'hFF; m_seg = 8'hFF;
    end else begin
      idx = (t / 4) % 8;
      slen = m_show ? cq.size() : q.size();
      if (idx < slen) begin
        d = m_show ? cq[slen - 1 - idx] : q[slen - 1 - idx];
        m_an = 8'hFF ^ 8'(1 << idx);
        m_seg = lut[d];
      end else begin
        m_an = 8'hFF; m_seg = 8'hFF;
      end
      t++;
      m_valid = 0; m_rej = 0;
      if (m_commit) begin
        m_commit = 0;
        m_rej = key_valid;
      end else if (key_valid) begin
        if (key_code <= 9) begin
          if (q.size() < 8) begin q.push_back(int'(key_code)); m_show = 0; end
          else m_rej = 1;
        end else if (key_code == 4'hA) begin
          q.delete(); m_show = 0;
        end else if (key_code == 4'hF) begin
          if (q.size() > 0) void'(q.pop_back()); else m_rej = 1;
        end else if (key_code == 4'hE) begin
          if (q.size() > 0) begin
            cq = q; m_val = pack(q); m_len = q.size(); m_show = 1; q.delete();
            m_valid = 1; m_commit = 1;
          end else m_rej = 1;
        end else m_rej = 1;
      end
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("entry_valid", 32'(entry_valid), 32'(m_valid));
    chk("key_reject", 32'(key_reject), 32'(m_rej));
    chk("entry_value", entry_value, m_val);
    chk("entry_len", 32'(entry_len), 32'(m_len));
    chk("seg_an", 32'(seg_an), 32'(m_an));
    chk("seg_out", 32'(seg_out), 32'(m_seg));
    if (entry_valid) ev_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1; key_code = c;
    tick();
    key_valid = 1'b0;
  endtask
  initial begin
    int e0, s0, s1, s2;
    tick(); tick();
    chk_en = 1'b1;
    rst_n = 1'b1;
    tick();
    key(4'd1); key(4'd2); tick();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_value", entry_value, 32'h0);
    chk("rst_len", 32'(entry_len), 32'h0);
    chk("rst_an", 32'(seg_an), 32'hFF);
    chk("rst_seg", 32'(seg_out), 32'hFF);
    chk("rst_no_valid", 32'(ev_cnt), 32'h0);
    rst_n = 1'b1;
    tick();
    key(4'd1); key(4'd2); key(4'd3); key(4'hE);
    chk("c123_valid", 32'(entry_valid), 32'h1);
    chk("c123_value", entry_value, 32'h00000123);
    chk("c123_len", 32'(entry_len), 32'h3);
    s0 = 0; s1 = 0; s2 = 0;
    repeat (40) begin
      tick();
      if (seg_an == 8'hFE) begin s0++; chk("scan_d0", 32'(seg_out), 32'hB0); end
      else if (seg_an == 8'hFD) begin s1++; chk("scan_d1", 32'(seg_out), 32'hA4); end
      else if (seg_an == 8'hFB) begin s2++; chk("scan_d2", 32'(seg_out), 32'hF9); end
      else chk("scan_off", 32'(seg_an), 32'hFF);
    end
    chk("scan_saw_all", 32'(s0 > 0 && s1 > 0 && s2 > 0), 32'h1);
    for (int i = 1; i <= 9; i++) key(4'(i));
    chk("ninth_reject", 32'(key_reject), 32'h1);
    key(4'hE);
    chk("c8_value", entry_value, 32'h12345678);
    chk("c8_len", 32'(entry_len), 32'h8);
    tick(); tick();
    key(4'd4); key(4'd5); key(4'hF); key(4'd6); key(4'hE);
    chk("c46_value", entry_value, 32'h46);
    chk("c46_len", 32'(entry_len), 32'h2);
    tick(); tick();
    key(4'hF);
    chk("bsp_empty_reject", 32'(key_reject), 32'h1);
    key(4'hE);
    chk("ent_empty_reject", 32'(key_reject), 32'h1);
    chk("ent_empty_novalid", 32'(entry_valid), 32'h0);
    e0 = ev_cnt;
    key(4'd7); key(4'hA); tick(); tick();
    chk("clr_an_off", 32'(seg_an), 32'hFF);
    chk("clr_no_commit", 32'(ev_cnt - e0), 32'h0);
    key(4'hC);
    chk("c_reject", 32'(key_reject), 32'h1);
    tick();
    key(4'd5);
    e0 = ev_cnt;
    key(4'hE);
    chk("b2b_valid", 32'(entry_valid), 32'h1);
    key(4'd9);
    chk("b2b_reject", 32'(key_reject), 32'h1);
    chk("b2b_valid_low", 32'(entry_valid), 32'h0);
    tick(); tick();
    chk("b2b_once", 32'(ev_cnt - e0), 32'h1);
    chk("b2b_value", entry_value, 32'h5);
    chk("b2b_len", 32'(entry_len), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences operator numeric entry from the 4x4 keypad scanner and owns the 8-digit common-anode seven-segment display.
- Consumes one-cycle key events (4-bit key code) and maintains a calculator-style BCD entry buffer with backspace, clear and enter.
- Publishes the committed value to downstream logic with a valid pulse.
- Time-multiplexes the entry, or the last committed value, onto seg_an/seg_out.

Parameters:
MAX_DIGITS, 8, entry buffer depth in BCD digits (1..8); must not exceed anode count.
SCAN_DIV, 100000, clk cycles per display digit slot (one refresh tick every SCAN_DIV cycles).

Ports:
clk  input  1  system clock; single clock domain.
rst_n  input  1  synchronous active-low reset.
key_valid  input  1  one-cycle pulse per accepted keypress, already synchronous to clk.
key_code  input  4  key value (0-9 digit, A clear, B/C/D unused, E enter, F backspace); sampled only when key_valid=1.
entry_value  output  32  committed value, 8 packed BCD nibbles, digit0 in [3:0], unused high nibbles 0.
entry_len  output  4  digit count of committed value (1..MAX_DIGITS).
entry_valid  output  1  one-cycle pulse when entry_value/entry_len update.
key_reject  output  1  one-cycle pulse when a key event is dropped.
seg_an  output  8  anode enables, active-low, bit i = digit i (rightmost = 0).
seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off).

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, buffer 0, len 0, show_committed 0, entry_value 0, entry_len 0, entry_valid 0, key_reject 0, prescaler 0, scan index 0, seg_an 8'hFF, seg_out 8'hFF. Reset mid-entry discards the buffer with no commit.
- FSM states:
  - IDLE: len=0.
  - EDIT: 1<=len<=MAX_DIGITS.
  - COMMIT: exactly one cycle.
- Key event at posedge N (key_valid=1). Effect is registered at N+1:
  - Digit 0-9, len<MAX_DIGITS: buf <= {buf[27:0], code}; len+1; show_committed <= 0; IDLE->EDIT.
  - Digit with len=MAX_DIGITS: ignored; key_reject=1 at N+1.
  - F (backspace), len>0: buf <= {4'h0, buf[31:4]}; len-1; EDIT->IDLE when len reaches 0.
  - F with len=0: key_reject.
  - A (clear): buf<=0, len<=0, ->IDLE, show_committed<=0. Never rejected.
  - E (enter), len>0: ->COMMIT. At N+1: entry_value<=buf, entry_len<=len, entry_valid=1, show_committed<=1, buffer and len cleared. COMMIT->IDLE at N+2.
  - E with len=0: key_reject.
  - B/C/D: key_reject.
  - key_valid during the COMMIT cycle: dropped with key_reject.
- entry_value/entry_len hold until the next commit. entry_valid and key_reject are never high in the same cycle.
- Display source:
  - show_committed=1: entry_value/entry_len.
  - Otherwise: buf/len.
  - Digit i is visible iff i < source length. With len=0 and show_committed=0, all anodes are off.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, scan index advances modulo MAX_DIGITS.
  - seg_an/seg_out are registered: seg_an = visible ? ~(8'b1<<idx) : 8'hFF; seg_out = SEG_LUT[nibble idx] when visible, else 8'hFF.
- Widths: len is 4-bit, saturating per the rules above; no arithmetic wrap is reachable.

Decomposition:
- Package kp_pkg holds:
  - Key-code constants: KEY_CLR=4'hA, KEY_ENT=4'hE, KEY_BSP=4'hF.
  - FSM state encoding (one-hot, 3 states).
  - SEG_LUT function with active-low patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; blank=FF.
- One sub-module, seg_scan_mux (prescaler, scan index, anode/segment registers). Inputs: 32-bit digits, 4-bit length. Outputs: seg_an, seg_out.

Test Plan:
- Reset: hold rst_n=0 three cycles mid-entry -> all outputs at reset values; entry_valid never pulses.
- Keys 1,2,3,E -> entry_valid one cycle after E; entry_value=32'h00000123, entry_len=3. With SCAN_DIV=4, the scan cycles an[0..2] showing 8'hB0, 8'hA4, 8'hF9 (digit0 = 3, digit1 = 2, digit2 = 1); an[3..7] stay off.
- Nine digits 1..9 -> ninth gives key_reject; E gives entry_value=32'h12345678, entry_len=8.
- Keys 4,5,F,6,E -> entry_value=32'h46, entry_len=2. Then F on empty buffer -> key_reject; E on empty buffer -> key_reject.
- Keys 7,A -> buffer empty, all anodes off, no commit. Key C -> key_reject only.
- key_valid asserted on consecutive cycles E then 9 -> 9 rejected, entry_valid=1 exactly once.
